// File: rtl/fpaddsub_pkg.sv
// Shared defaults and derived-width helpers for the FP add/sub normalization stages.
package fpaddsub_pkg;

  localparam int unsigned EXP_W_DEF    = 8;
  localparam int unsigned MAN_W_DEF    = 23;
  localparam int unsigned STICKY_W_DEF = 7;
  localparam int unsigned SHIFT_W_DEF  = 5;
  localparam int unsigned TAG_W_DEF    = 4;

  function automatic int unsigned sum_w(input int unsigned man_w, input int unsigned sticky_w);
    return man_w + sticky_w + 3;
  endfunction

  // Smallest biased exponent that lands in the infinity range (all-ones).
  function automatic int unsigned ovf_thresh(input int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpaddsub_ns2_core.sv
// Combinational field extraction (from the raw input) and exponent finishing
// (from the stage-1 registered exponent) for normalization-shift stage 2.
module fpaddsub_ns2_core
  import fpaddsub_pkg::*;
#(
  parameter int unsigned EXP_W    = EXP_W_DEF,
  parameter int unsigned MAN_W    = MAN_W_DEF,
  parameter int unsigned STICKY_W = STICKY_W_DEF,
  parameter int unsigned SHIFT_W  = SHIFT_W_DEF,
  localparam int unsigned SUM_W   = sum_w(MAN_W, STICKY_W)
) (
  input  logic [SUM_W-1:0] sum_i,
  input  logic [EXP_W-1:0] cexp_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [EXP_W:0]   exp_ok_o,
  output logic             msb_o,
  output logic [MAN_W-1:0] norm_m_o,
  output logic             fg_o,
  output logic             r_o,
  output logic             s_o,
  output logic             zero_o,
  input  logic [EXP_W:0]   s1_exp_ok_i,
  input  logic             s1_msb_i,
  output logic [EXP_W:0]   norm_e_o,
  output logic             neg_e_o,
  output logic             ovf_o
);

  localparam logic [EXP_W:0] OVF_TH = (EXP_W+1)'(ovf_thresh(EXP_W));

  always_comb begin
    exp_ok_o = {1'b0, cexp_i} - (EXP_W+1)'(shift_i);
    msb_o    = sum_i[SUM_W-1];
    norm_m_o = sum_i[SUM_W-2:STICKY_W+2];
    fg_o     = sum_i[STICKY_W+1];
    r_o      = sum_i[STICKY_W];
    s_o      = |sum_i[STICKY_W-1:0];
    zero_o   = ~|sum_i;
  end

  always_comb begin
    norm_e_o = s1_exp_ok_i + (EXP_W+1)'(s1_msb_i);
    neg_e_o  = s1_exp_ok_i[EXP_W];
    ovf_o    = ~neg_e_o & (norm_e_o >= OVF_TH);
  end

endmodule

// File: rtl/fpaddsub_normalize_shift2_pipe.sv
// Two-stage valid/ready pipelined normalization-shift stage 2 with tag sideband.
module fpaddsub_normalize_shift2_pipe
  import fpaddsub_pkg::*;
#(
  parameter int unsigned EXP_W    = EXP_W_DEF,
  parameter int unsigned MAN_W    = MAN_W_DEF,
  parameter int unsigned STICKY_W = STICKY_W_DEF,
  parameter int unsigned SHIFT_W  = SHIFT_W_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  localparam int unsigned SUM_W   = sum_w(MAN_W, STICKY_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic [EXP_W-1:0]   in_cexp,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W-1:0]   out_norm_m,
  output logic [EXP_W:0]     out_norm_e,
  output logic               out_fg,
  output logic               out_r,
  output logic               out_s,
  output logic               out_zero,
  output logic               out_neg_e,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  logic             s1_valid_q;
  logic [EXP_W:0]   s1_exp_ok_q;
  logic             s1_msb_q, s1_fg_q, s1_r_q, s1_s_q, s1_zero_q;
  logic [MAN_W-1:0] s1_norm_m_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q;
  logic [MAN_W-1:0] out_norm_m_q;
  logic [EXP_W:0]   out_norm_e_q;
  logic             out_fg_q, out_r_q, out_s_q, out_zero_q, out_neg_e_q, out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [EXP_W:0]   exp_ok_d, norm_e_d;
  logic             msb_d, fg_d, r_d, s_d, zero_d, neg_e_d, ovf_d;
  logic [MAN_W-1:0] norm_m_d;
  logic             adv1, adv2;

  fpaddsub_ns2_core #(
    .EXP_W   (EXP_W),
    .MAN_W   (MAN_W),
    .STICKY_W(STICKY_W),
    .SHIFT_W (SHIFT_W)
  ) u_core (
    .sum_i      (in_sum),
    .cexp_i     (in_cexp),
    .shift_i    (in_shift),
    .exp_ok_o   (exp_ok_d),
    .msb_o      (msb_d),
    .norm_m_o   (norm_m_d),
    .fg_o       (fg_d),
    .r_o        (r_d),
    .s_o        (s_d),
    .zero_o     (zero_d),
    .s1_exp_ok_i(s1_exp_ok_q),
    .s1_msb_i   (s1_msb_q),
    .norm_e_o   (norm_e_d),
    .neg_e_o    (neg_e_d),
    .ovf_o      (ovf_d)
  );

  always_comb begin
    adv2     = ~out_valid_q | out_ready;
    adv1     = ~s1_valid_q | adv2;
    in_ready = adv1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exp_ok_q <= '0;
      s1_msb_q    <= 1'b0;
      s1_norm_m_q <= '0;
      s1_fg_q     <= 1'b0;
      s1_r_q      <= 1'b0;
      s1_s_q      <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_tag_q    <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_exp_ok_q <= exp_ok_d;
        s1_msb_q    <= msb_d;
        s1_norm_m_q <= norm_m_d;
        s1_fg_q     <= fg_d;
        s1_r_q      <= r_d;
        s1_s_q      <= s_d;
        s1_zero_q   <= zero_d;
        s1_tag_q    <= in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_norm_m_q <= '0;
      out_norm_e_q <= '0;
      out_fg_q     <= 1'b0;
      out_r_q      <= 1'b0;
      out_s_q      <= 1'b0;
      out_zero_q   <= 1'b0;
      out_neg_e_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_tag_q    <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_norm_m_q <= s1_norm_m_q;
        out_norm_e_q <= norm_e_d;
        out_fg_q     <= s1_fg_q;
        out_r_q      <= s1_r_q;
        out_s_q      <= s1_s_q;
        out_zero_q   <= s1_zero_q;
        out_neg_e_q  <= neg_e_d;
        out_ovf_q    <= ovf_d;
        out_tag_q    <= s1_tag_q;
      end
    end
  end

  always_comb begin
    out_valid  = out_valid_q;
    out_norm_m = out_norm_m_q;
    out_norm_e = out_norm_e_q;
    out_fg     = out_fg_q;
    out_r      = out_r_q;
    out_s      = out_s_q;
    out_zero   = out_zero_q;
    out_neg_e  = out_neg_e_q;
    out_ovf    = out_ovf_q;
    out_tag    = out_tag_q;
  end

endmodule

// File: tb/tb_fpaddsub_normalize_shift2_pipe.sv
// Directed bench for fpaddsub_normalize_shift2_pipe at default parameters (SUM_W=33).
module tb_fpaddsub_normalize_shift2_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_sum;
  logic [7:0]  in_cexp;
  logic [4:0]  in_shift;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_norm_m;
  logic [8:0]  out_norm_e;
  logic        out_fg, out_r, out_s, out_zero, out_neg_e, out_ovf;
  logic [3:0]  out_tag;

  int unsigned checks = 0;
  int unsigned failures = 0;

  fpaddsub_normalize_shift2_pipe #(
    .EXP_W(8), .MAN_W(23), .STICKY_W(7), .SHIFT_W(5), .TAG_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cexp   (in_cexp),
    .in_shift  (in_shift),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_norm_m(out_norm_m),
    .out_norm_e(out_norm_e),
    .out_fg    (out_fg),
    .out_r     (out_r),
    .out_s     (out_s),
    .out_zero  (out_zero),
    .out_neg_e (out_neg_e),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [32:0] sum, input logic [7:0] cexp,
                       input logic [4:0] sh, input logic [3:0] tag);
    in_valid = 1'b1;
    in_sum   = sum;
    in_cexp  = cexp;
    in_shift = sh;
    in_tag   = tag;
  endtask

  // One isolated beat: accept, check bubble, then check every output field.
  task automatic single(input string nm, input logic [32:0] sum, input logic [7:0] cexp,
                        input logic [4:0] sh, input logic [3:0] tag,
                        input logic [22:0] em, input logic [8:0] ee,
                        input logic efg, input logic er, input logic es,
                        input logic ez, input logic en, input logic eo);
    drive(sum, cexp, sh, tag);
    #1 chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({nm, ".lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".norm_m"}, 64'(out_norm_m), 64'(em));
    chk({nm, ".norm_e"}, 64'(out_norm_e), 64'(ee));
    chk({nm, ".grs"}, 64'({out_fg, out_r, out_s}), 64'({efg, er, es}));
    chk({nm, ".zero"}, 64'(out_zero), 64'(ez));
    chk({nm, ".neg_e"}, 64'(out_neg_e), 64'(en));
    chk({nm, ".ovf"}, 64'(out_ovf), 64'(eo));
    chk({nm, ".tag"}, 64'(out_tag), 64'(tag));
    tick();
    chk({nm, ".drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_sum = '1; in_cexp = '1; in_shift = '0; in_tag = 4'hF;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.fields", 64'({out_norm_m, out_norm_e, out_fg, out_r, out_s, out_zero, out_neg_e, out_ovf, out_tag}), 64'd0);

    single("msb_only", 33'h1_0000_0000, 8'h80, 5'd0, 4'h1, 23'h0, 9'h081, 0, 0, 0, 0, 0, 0);
    single("zero_sum", 33'h0, 8'h10, 5'd3, 4'h2, 23'h0, 9'h00D, 0, 0, 0, 1, 0, 0);
    single("grs", 33'h0_0000_01C1, 8'h10, 5'd0, 4'h3, 23'h0, 9'h010, 1, 1, 1, 0, 0, 0);
    single("neg_e", 33'h0_0000_0200, 8'h03, 5'd5, 4'h4, 23'h1, 9'h1FE, 0, 0, 0, 0, 1, 0);
    single("ovf_msb", 33'h1_FFFF_FFFF, 8'hFE, 5'd0, 4'h5, 23'h7FFFFF, 9'h0FF, 1, 1, 1, 0, 0, 1);
    single("ovf_edge", 33'h0_0000_0200, 8'hFF, 5'd0, 4'h6, 23'h1, 9'h0FF, 0, 0, 0, 0, 0, 1);
    single("below_ovf", 33'h0_0000_0200, 8'hFE, 5'd0, 4'h7, 23'h1, 9'h0FE, 0, 0, 0, 0, 0, 0);
    single("wrap_to_0", 33'h1_0000_0000, 8'h00, 5'd1, 4'h8, 23'h0, 9'h000, 0, 0, 0, 0, 1, 0);

    // Back-to-back: beat i carries norm_m=i+1, norm_e=0x40-i, tag=i.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(33'((i + 1) << 9), 8'h40, 5'(i), 4'(i));
      else in_valid = 1'b0;
      #1;
      if (i < 8) chk("b2b.in_ready", 64'(in_ready), 64'd1);
      tick();
      if (i >= 1 && i <= 8) begin
        chk("b2b.valid", 64'(out_valid), 64'd1);
        chk("b2b.tag", 64'(out_tag), 64'(i - 1));
        chk("b2b.norm_m", 64'(out_norm_m), 64'(i));
        chk("b2b.norm_e", 64'(out_norm_e), 64'(9'h040 - 9'(i - 1)));
      end else begin
        chk("b2b.idle", 64'(out_valid), 64'd0);
      end
    end

    // Backpressure: tags 8..11 offered while out_ready=0 for 5 cycles.
    out_ready = 1'b0;
    drive(33'h0_0000_0200, 8'h20, 5'd0, 4'd8);
    #1 chk("bp.c0_ready", 64'(in_ready), 64'd1);
    tick();
    drive(33'h0_0000_0400, 8'h21, 5'd0, 4'd9);
    #1 chk("bp.c1_ready", 64'(in_ready), 64'd1);
    tick();
    drive(33'h0_0000_0600, 8'h22, 5'd0, 4'd10);
    for (int c = 2; c < 5; c++) begin
      #1;
      chk("bp.stall_ready", 64'(in_ready), 64'd0);
      chk("bp.stall_valid", 64'(out_valid), 64'd1);
      chk("bp.stall_tag", 64'(out_tag), 64'd8);
      chk("bp.stall_m", 64'(out_norm_m), 64'd1);
      chk("bp.stall_e", 64'(out_norm_e), 64'h020);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp.out9", 64'(out_tag), 64'd9);
    chk("bp.out9_e", 64'(out_norm_e), 64'h021);
    drive(33'h0_0000_0800, 8'h23, 5'd0, 4'd11);
    tick();
    in_valid = 1'b0;
    chk("bp.out10", 64'(out_tag), 64'd10);
    chk("bp.out10_m", 64'(out_norm_m), 64'd3);
    tick();
    chk("bp.out11_valid", 64'(out_valid), 64'd1);
    chk("bp.out11", 64'(out_tag), 64'd11);
    chk("bp.out11_m", 64'(out_norm_m), 64'd4);
    tick();
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Mid-stream reset with tags 12 (output) and 13 (stage 1) in flight.
    drive(33'h1_0000_0000, 8'h50, 5'd0, 4'd12);
    tick();
    drive(33'h1_0000_0000, 8'h51, 5'd0, 4'd13);
    tick();
    chk("rst.pre_tag", 64'(out_tag), 64'd12);
    rst = 1'b1;
    drive(33'h1_0000_0000, 8'h52, 5'd0, 4'd14);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.fields", 64'({out_norm_m, out_norm_e, out_fg, out_r, out_s, out_zero, out_neg_e, out_ovf, out_tag}), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst.no_ghost", 64'(out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
